// File: rtl/microwave_controller.sv
// -----------------------------------------------------------------------------
// microwave_controller
//   Cook-cycle sequencer. Assembles a 4-digit mm:ss BCD cook time from keypad
//   digit strobes, counts it down on timebase ticks, gates the magnetron and
//   the keypad, and reacts to start/stop/clear buttons and the door switch.
//
// Parameters
//   DONE_TICKS  ticks the DONE indication is held before returning to IDLE (1..15)
//
// Ports
//   clk          in   system clock, rising edge
//   resetn       in   synchronous active-low reset
//   key_d        in   BCD digit, valid while key_loadn is low
//   key_loadn    in   active-low digit strobe (falling edge = one digit)
//   pgt_1Hz      in   timebase, rising edge = one tick
//   startn       in   start button, active-low
//   stopn        in   stop/pause button, active-low
//   clearn       in   clear button, active-low
//   door_closed  in   1 = door closed
//   time_bcd     out  {min_tens, min_ones, sec_tens, sec_ones}
//   mag_on       out  magnetron enable (COOK only)
//   keypad_en    out  encoder enable (IDLE and SET only)
//   done         out  cook-complete indication (DONE only)
//   state_o      out  state code: IDLE=0 SET=1 COOK=2 PAUSE=3 DONE=4
// -----------------------------------------------------------------------------
module microwave_controller #(
  parameter int unsigned DONE_TICKS = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [3:0]  key_d,
  input  logic        key_loadn,
  input  logic        pgt_1Hz,
  input  logic        startn,
  input  logic        stopn,
  input  logic        clearn,
  input  logic        door_closed,
  output logic [15:0] time_bcd,
  output logic        mag_on,
  output logic        keypad_en,
  output logic        done,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] LP_DONE_LAST = 4'(DONE_TICKS - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_time;
  logic [15:0] w_time_nxt;
  logic [3:0]  r_done_cnt;
  logic [3:0]  w_done_cnt_nxt;
  logic        r_mag_on;
  logic        r_keypad_en;
  logic        r_done;

  // Previous-sample registers for edge detection.
  logic        r_key_loadn_q;
  logic        r_startn_q;
  logic        r_stopn_q;
  logic        r_clearn_q;
  logic        r_pgt_q;
  logic        r_door_q;

  logic        w_digit;
  logic        w_digit_ok;
  logic        w_start;
  logic        w_stop;
  logic        w_clear;
  logic        w_tick;
  logic        w_door_fall;
  logic        w_time_zero;
  logic        w_start_ok;
  logic [15:0] w_time_shift;
  logic [15:0] w_time_dec;

  // Events are formed from the live input against the previous sample, so an
  // edge first seen at clock edge n acts at edge n.
  assign w_digit     = r_key_loadn_q & ~key_loadn;
  assign w_digit_ok  = w_digit & (key_d <= 4'd9);
  assign w_start     = r_startn_q & ~startn;
  assign w_stop      = r_stopn_q & ~stopn;
  assign w_clear     = r_clearn_q & ~clearn;
  assign w_tick      = ~r_pgt_q & pgt_1Hz;
  assign w_door_fall = r_door_q & ~door_closed;

  assign w_time_zero  = (r_time == 16'h0000);
  assign w_start_ok   = w_start & door_closed & ~w_time_zero;
  assign w_time_shift = {r_time[11:0], key_d};

  // BCD mm:ss decrement. Seconds tens are not range-limited, so entered
  // values above 59 count down digit-wise without normalisation.
  always_comb begin
    w_time_dec = r_time;
    if (r_time[3:0] != 4'd0) begin
      w_time_dec[3:0] = r_time[3:0] - 4'd1;
    end else if (r_time[7:4] != 4'd0) begin
      w_time_dec[7:4] = r_time[7:4] - 4'd1;
      w_time_dec[3:0] = 4'd9;
    end else begin
      w_time_dec[7:0] = 8'h59;
      if (r_time[11:8] != 4'd0) begin
        w_time_dec[11:8] = r_time[11:8] - 4'd1;
      end else begin
        w_time_dec[11:8]  = 4'd9;
        w_time_dec[15:12] = r_time[15:12] - 4'd1;
      end
    end
  end

  // Next-state logic. Priority: clear > stop > door open > start > tick >
  // digit. An event that has no effect in the current state does not mask a
  // lower-priority one.
  always_comb begin
    w_state_nxt    = r_state;
    w_time_nxt     = r_time;
    w_done_cnt_nxt = r_done_cnt;
    if (w_clear) begin
      w_state_nxt    = S_IDLE;
      w_time_nxt     = '0;
      w_done_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_digit_ok) begin
            w_time_nxt  = w_time_shift;
            w_state_nxt = S_SET;
          end
        end
        S_SET: begin
          if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_time_nxt  = '0;
          end else if (w_start_ok) begin
            w_state_nxt = S_COOK;
          end else if (w_digit_ok) begin
            w_time_nxt = w_time_shift;
          end
        end
        S_COOK: begin
          if (w_stop || !door_closed) begin
            w_state_nxt = S_PAUSE;
          end else if (w_tick) begin
            w_time_nxt = w_time_dec;
            if (w_time_dec == 16'h0000) begin
              w_state_nxt    = S_DONE;
              w_done_cnt_nxt = '0;
            end
          end
        end
        S_PAUSE: begin
          if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_time_nxt  = '0;
          end else if (door_closed && w_start) begin
            w_state_nxt = S_COOK;
          end
        end
        S_DONE: begin
          if (w_stop || w_door_fall) begin
            w_state_nxt    = S_IDLE;
            w_done_cnt_nxt = '0;
          end else if (w_tick) begin
            if (r_done_cnt == LP_DONE_LAST) begin
              w_state_nxt    = S_IDLE;
              w_done_cnt_nxt = '0;
            end else begin
              w_done_cnt_nxt = r_done_cnt + 4'd1;
            end
          end
        end
        default: begin
          w_state_nxt    = S_IDLE;
          w_time_nxt     = '0;
          w_done_cnt_nxt = '0;
        end
      endcase
    end
  end

  // State, time and registered outputs. Outputs are decoded from the next
  // state so they change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_time        <= '0;
      r_done_cnt    <= '0;
      r_mag_on      <= 1'b0;
      r_keypad_en   <= 1'b1;
      r_done        <= 1'b0;
      r_key_loadn_q <= 1'b1;
      r_startn_q    <= 1'b1;
      r_stopn_q     <= 1'b1;
      r_clearn_q    <= 1'b1;
      r_pgt_q       <= 1'b0;
      // Reset to 0 so a door that is open out of reset is not seen as a fall.
      r_door_q      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_time        <= w_time_nxt;
      r_done_cnt    <= w_done_cnt_nxt;
      r_mag_on      <= (w_state_nxt == S_COOK);
      r_keypad_en   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_SET);
      r_done        <= (w_state_nxt == S_DONE);
      r_key_loadn_q <= key_loadn;
      r_startn_q    <= startn;
      r_stopn_q     <= stopn;
      r_clearn_q    <= clearn;
      r_pgt_q       <= pgt_1Hz;
      r_door_q      <= door_closed;
    end
  end

  assign time_bcd  = r_time;
  assign mag_on    = r_mag_on;
  assign keypad_en = r_keypad_en;
  assign done      = r_done;
  assign state_o   = r_state;

endmodule
